// File: rtl/mont_pkg.sv
// Shared constants, FSM states and operand-select encoding for the
// bit-serial Montgomery multiplier.
package mont_pkg;

    localparam int N_BITS = 1024;
    localparam int ADD_W  = 1027;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_PRE_W,
        S_SEL,
        S_ADD,
        S_ADD_W,
        S_SHIFT,
        S_SUB,
        S_SUB_W,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_M    = 2'b01,
        SEL_B    = 2'b10,
        SEL_BM   = 2'b11
    } sel_e;

    // Operand choice for one iteration: the low bit makes c + a_i*B + q*M even.
    function automatic sel_e sel_of(input logic a_bit, input logic c_bit, input logic b0);
        return sel_e'({a_bit, c_bit ^ (a_bit & b0)});
    endfunction

endpackage

// File: rtl/montgomery_mul_if.sv
// Request/response bundle between exponentiation control and montgomery_mul.
interface montgomery_mul_if;
    import mont_pkg::*;

    logic              start;
    logic [N_BITS-1:0] in_a;
    logic [N_BITS-1:0] in_b;
    logic [N_BITS-1:0] in_m;
    logic [N_BITS-1:0] result;
    logic              done;
    logic              busy;

    modport master (output start, in_a, in_b, in_m, input  result, done, busy);
    modport slave  (input  start, in_a, in_b, in_m, output result, done, busy);

endinterface

// File: rtl/montgomery_mul_mpadder.sv
// mpadder: 1027-bit add/subtract unit with a start/done handshake.
// result[1027] is the carry of a sum or the borrow of a difference.
module mpadder
    import mont_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [ADD_W-1:0] in_a,
    input  logic [ADD_W-1:0] in_b,
    output logic [ADD_W:0]   result,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= start;
            if (start)
                result <= subtract ? ({1'b0, in_a} - {1'b0, in_b})
                                   : ({1'b0, in_a} + {1'b0, in_b});
        end
    end

endmodule

// File: rtl/montgomery_mul.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-N_BITS mod M, built around
// a single shared mpadder that handles B+M, every accumulate and the final subtract.
module montgomery_mul
    import mont_pkg::*;
#(
    parameter int N_BITS = mont_pkg::N_BITS
) (
    input  logic clk,
    input  logic resetn,
    montgomery_mul_if.slave bus
);

    state_e state_r, state_nx;

    logic [N_BITS-1:0] a_r, b_r, m_r, result_r;
    logic [N_BITS+1:0] bm_r, c_r, operand;
    logic [9:0]        i_r, i_inc;
    logic              last_iter;
    sel_e              sel_cur, sel_nxt;

    logic              add_start, add_sub, add_done;
    logic [ADD_W-1:0]  add_a, add_b;
    logic [ADD_W:0]    add_res;
    logic              unused_sum_msb;

    assign unused_sum_msb = add_res[ADD_W-1];

    assign i_inc     = i_r + 10'd1;
    assign last_iter = (i_r == 10'd1023);
    assign sel_cur   = sel_of(a_r[i_r], c_r[0], b_r[0]);
    // Lookahead for the iteration after a shift: bit 1 of c_r becomes bit 0.
    assign sel_nxt   = sel_of(a_r[i_inc], c_r[1], b_r[0]);

    always_comb begin
        operand = '0;
        case (sel_cur)
            SEL_M:   operand = {2'b00, m_r};
            SEL_B:   operand = {2'b00, b_r};
            SEL_BM:  operand = bm_r;
            default: operand = '0;
        endcase
    end

    mpadder u_adder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start),
        .subtract (add_sub),
        .in_a     (add_a),
        .in_b     (add_b),
        .result   (add_res),
        .done     (add_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_r <= S_IDLE;
        else         state_r <= state_nx;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_nx  = state_r;
        add_start = 1'b0;
        add_sub   = 1'b0;
        add_a     = '0;
        add_b     = '0;
        case (state_r)
            S_IDLE: if (bus.start) state_nx = S_PRE;
            S_PRE, S_PRE_W: begin
                add_start = (state_r == S_PRE);
                add_a     = {3'b000, b_r};
                add_b     = {3'b000, m_r};
                if (state_r == S_PRE) state_nx = S_PRE_W;
                else if (add_done)    state_nx = (sel_cur == SEL_ZERO) ? S_SEL : S_ADD;
            end
            S_SEL, S_SHIFT: begin
                if (last_iter)                 state_nx = S_SUB;
                else if (sel_nxt == SEL_ZERO)  state_nx = S_SEL;
                else                           state_nx = S_ADD;
            end
            S_ADD, S_ADD_W: begin
                add_start = (state_r == S_ADD);
                add_a     = {1'b0, c_r};
                add_b     = {1'b0, operand};
                if (state_r == S_ADD) state_nx = S_ADD_W;
                else if (add_done)    state_nx = S_SHIFT;
            end
            S_SUB, S_SUB_W: begin
                add_start = (state_r == S_SUB);
                add_sub   = 1'b1;
                add_a     = {1'b0, c_r};
                add_b     = {3'b000, m_r};
                if (state_r == S_SUB) state_nx = S_SUB_W;
                else if (add_done)    state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            c_r      <= '0;
            i_r      <= '0;
            result_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: if (bus.start) begin
                    c_r <= '0;
                    i_r <= '0;
                end
                S_ADD_W: if (add_done) c_r <= add_res[N_BITS+1:0];
                S_SEL, S_SHIFT: begin
                    c_r <= c_r >> 1;
                    i_r <= i_inc;
                end
                // A borrow means c_r < M already, so it is the reduced result.
                S_SUB_W: if (add_done)
                    result_r <= add_res[ADD_W] ? c_r[N_BITS-1:0] : add_res[N_BITS-1:0];
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded before first use.
    always_ff @(posedge clk) begin
        if (state_r == S_IDLE && bus.start) begin
            a_r <= bus.in_a;
            b_r <= bus.in_b;
            m_r <= bus.in_m;
        end
        if (state_r == S_PRE_W && add_done)
            bm_r <= add_res[N_BITS+1:0];
    end

    assign bus.result = result_r;
    assign bus.done   = (state_r == S_DONE);
    assign bus.busy   = (state_r != S_IDLE);

endmodule

// File: doc/montgomery_mul.md
# montgomery_mul

- Bit-serial Montgomery modular multiplier: computes A·B·2^-1024 mod M for 1024-bit operands.
- Sits directly upstream of `mpadder`, the 1027-bit add/subtract unit. It owns the only `mpadder` instance and sequences every operand into it.
- It consumes every sum `mpadder` returns and applies the conditional final subtraction.
- Higher-level exponentiation control instantiates it.

## Interface
Parameters:
- N_BITS, 1024, operand/modulus width; fixed by the 1027-bit `mpadder` datapath.

Ports:
- clk  input  1  clock, all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; latches in_a/in_b/in_m; ignored while busy
- in_a  input  1024  multiplier A, must be < M
- in_b  input  1024  multiplicand B, must be < M
- in_m  input  1024  modulus M, must be odd
- result  output  1024  A·B·R^-1 mod M, R = 2^1024; valid from done, held until next accepted start
- done  output  1  one-cycle pulse, result valid
- busy  output  1  high from the cycle after accepted start through the done cycle

## Operation
- Registers: a_r, b_r, m_r (1024); bm_r (1026) = B+M; c_r (1026) accumulator; i_r (10-bit) bit index.
- On start in IDLE:
  - latch operands;
  - c_r = 0, i_r = 0;
  - go to PRE.
- PRE / PRE_W:
  - pulse adder start with in_a = B, in_b = M, subtract = 0;
  - on adder done, bm_r = result[1025:0].
- Per iteration i (0..1023):
  - sel = {a_r[i], c_r[0] ^ (a_r[i] & b_r[0])};
  - operand = 0 / M / B / B+M for sel 00 / 01 / 10 / 11.
- sel == 00: go straight to SHIFT; no adder call.
- Otherwise, ADD / ADD_W:
  - pulse adder start with in_a = c_r, in_b = operand, subtract = 0;
  - on done, c_r = result[1025:0] (sum is even by construction).
- SHIFT:
  - c_r = c_r >> 1;
  - i_r++;
  - after i = 1023, go to SUB; else back to the select step.
- SUB / SUB_W:
  - adder computes c_r − M with subtract = 1;
  - if result[1027] == 0 (no borrow): result = diff[1023:0]; else result = c_r[1023:0].
- DONE: done = 1 for one cycle, then IDLE.
- Invariant: c_r < 2M at every SHIFT exit, so a single final subtraction suffices.
- Adder operands are zero-extended to 1027 bits.
- Adder handshake:
  - start to `mpadder` is exactly one cycle;
  - in_a, in_b and subtract stay stable from that pulse until the cycle adder done is sampled high;
  - never wait a fixed latency; always wait for done.
- Reset: resetn low at any clock edge, including mid-operation, gives:
  - state = IDLE, done = 0, busy = 0, result = 0, c_r = 0;
  - adder start = 0.
  - A multiplication in progress is abandoned.
- start while busy: ignored, no effect on the running operation.
- start in the DONE cycle: ignored.
- Inputs violating A,B < M or M odd: result undefined; no hang (loop count is fixed).

## Timing
- Let W = cycles from adder start pulse to adder done sampled high, W ≥ 1.
- Total latency from start to done = (1+W) + Σ_i [sel_i ≠ 00 ? (2+W) : 1] + (1+W) + 1.
- Minimum latency (A = 0, all sel = 00) = 2W + 1027.
- result updates in the cycle before done and is stable in the done cycle.
- busy falls the cycle after done.
- Back-to-back: a start accepted in the cycle after done begins a new operation.

## Structure
- Package mont_pkg:
  - N_BITS, ADD_W = 1027;
  - state enum {IDLE, PRE, PRE_W, SEL, ADD, ADD_W, SHIFT, SUB, SUB_W, DONE};
  - operand-select enum {SEL_ZERO, SEL_M, SEL_B, SEL_BM}.
- One sub-module, the existing `mpadder` instance. No other hierarchy.
- Operand mux, counter and FSM stay in montgomery_mul.

## Test plan
- M = 2^1024−1 (so R ≡ 1 and the result is A·B mod M), A = 3, B = 5 → result = 15; done pulses exactly once; busy low afterwards.
- Same M, A = B = M−1 → result = 1; the final subtraction path is exercised.
- A = 0, B = 7, M = 13 → result = 0; latency equals 2W + 1027 exactly; no adder start during the loop.
- Random odd 1024-bit M with A, B < M (1000 vectors) → result matches the reference model A·B·2^-1024 mod M.
- resetn low at iteration 500 → next cycle result = 0, done = 0, busy = 0; a new start then completes correctly.
- start pulsed again at iteration 10 with different operands → ignored; result equals the first operation's value.
